xintf_reg_responder: RTL and testbench

//  FPGA-side responder for the DSP XINTF asynchronous bus: 16-bit register file of DEPTH words mapped at BASE.
//  DSP writes and reads the file through nCS/nRD/nWR/address/data. Fabric logic reads any word and may update any word.

---
 rtl/xintf_reg_responder_if.sv | 24 ++
 rtl/xintf_reg_responder.sv | 173 +++++++++++++++++
 tb/tb_xintf_reg_responder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xintf_reg_responder_if.sv
// Fabric-side port of the XINTF register responder: fabric access to the
// register file plus the DSP write/read notifications.
interface xintf_reg_responder_if #(
   parameter int AW = 4
) ();
   logic [AW-1:0] fab_idx;
   logic          fab_we;
   logic [15:0]   fab_wdata;
   logic [15:0]   fab_rdata;
   logic          wr_strobe;
   logic [AW-1:0] wr_idx;
   logic [15:0]   wr_value;
   logic          rd_strobe;

   modport master (
      output fab_idx, fab_we, fab_wdata,
      input  fab_rdata, wr_strobe, wr_idx, wr_value, rd_strobe
   );

   modport slave (
      input  fab_idx, fab_we, fab_wdata,
      output fab_rdata, wr_strobe, wr_idx, wr_value, rd_strobe
   );
endinterface

// File: rtl/xintf_reg_responder.sv
// DSP XINTF asynchronous-bus responder: a DEPTH-word 16-bit register file at
// BASE, written/read by the DSP and shared with fabric logic.
module xintf_reg_responder #(
   parameter logic [14:0] BASE    = 15'h3FF0,
   parameter int          DEPTH   = 16,
   parameter int          AW      = 4,
   parameter int          MIN_ACT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [14:0] address,
   input  logic        nCS,
   input  logic        nRD,
   input  logic        nWR,
   inout  wire  [15:0] data,
   xintf_reg_responder_if.slave fab
);
   localparam logic [15:0]   WIN_LO    = {1'b0, BASE};
   localparam logic [15:0]   WIN_HI    = WIN_LO + 16'(DEPTH);
   localparam logic [AW-1:0] BASE_LO   = BASE[AW-1:0];
   localparam logic [7:0]    MIN_ACT_C = 8'(MIN_ACT);

   typedef enum logic [1:0] {WR_IDLE, WR_LOW, WR_DONE} wr_state_e;

   // Window end is computed in 16 bits so BASE+DEPTH never wraps into the window.
   function automatic logic in_window(input logic [14:0] a);
      return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
   endfunction

   logic          ncs_s1_q, ncs_s2_q;
   logic          nrd_s1_q, nrd_s2_q, nrd_s3_q;
   logic          nwr_s1_q, nwr_s2_q;
   logic [14:0]   addr_s1_q, addr_s2_q;
   logic [15:0]   data_s1_q, data_s2_q;

   wr_state_e     state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic [1:0]    settle_q, settle_d;
   logic          wr_strobe_q, wr_strobe_d;
   logic [AW-1:0] wr_idx_q, wr_idx_d;
   logic [15:0]   wr_value_q, wr_value_d;
   logic          rd_strobe_q, rd_strobe_d;
   logic [15:0]   rd_q, rd_d;
   logic [15:0]   fab_rdata_q, fab_rdata_d;
   logic [15:0]   mem_q [DEPTH];
   logic [15:0]   mem_d [DEPTH];

   logic          hit;
   logic [AW-1:0] idx;
   logic          commit;
   logic          drive_en;

   assign hit = !ncs_s2_q && in_window(addr_s2_q);
   assign idx = addr_s2_q[AW-1:0] - BASE_LO;

   // Output enable uses the raw pins so the bus is released the moment the DSP lets go.
   assign drive_en = !nCS && !nRD && nWR && in_window(address);
   assign data     = drive_en ? rd_q : 16'bz;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      settle_d    = (settle_q == 2'd2) ? 2'd2 : settle_q + 2'd1;
      // A new write may start only after nWR has been seen high on a settled sync chain.
      armed_d     = armed_q | (nwr_s2_q && settle_q == 2'd2);
      commit      = 1'b0;
      wr_strobe_d = 1'b0;
      wr_idx_d    = wr_idx_q;
      wr_value_d  = wr_value_q;

      case (state_q)
         WR_IDLE: begin
            if (armed_q && !nwr_s2_q && hit) begin
               armed_d = 1'b0;
               cnt_d   = 8'd1;
               if (cnt_d >= MIN_ACT_C) begin
                  commit  = 1'b1;
                  state_d = WR_DONE;
               end else begin
                  state_d = WR_LOW;
               end
            end
         end
         WR_LOW: begin
            if (nwr_s2_q || !hit) begin
               state_d = WR_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d >= MIN_ACT_C) begin
                  commit  = 1'b1;
                  state_d = WR_DONE;
               end
            end
         end
         WR_DONE: begin
            if (nwr_s2_q || ncs_s2_q) state_d = WR_IDLE;
         end
         default: state_d = WR_IDLE;
      endcase

      if (commit) begin
         wr_strobe_d = 1'b1;
         wr_idx_d    = idx;
         wr_value_d  = data_s2_q;
      end

      // DSP commit is applied last so it wins a same-index collision with the fabric.
      mem_d = mem_q;
      if (fab.fab_we) mem_d[fab.fab_idx] = fab.fab_wdata;
      if (commit)     mem_d[idx]         = data_s2_q;

      rd_d        = mem_q[idx];
      fab_rdata_d = mem_q[fab.fab_idx];
      rd_strobe_d = nrd_s3_q && !nrd_s2_q && hit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ncs_s1_q    <= 1'b1;
         ncs_s2_q    <= 1'b1;
         nrd_s1_q    <= 1'b1;
         nrd_s2_q    <= 1'b1;
         nrd_s3_q    <= 1'b1;
         nwr_s1_q    <= 1'b1;
         nwr_s2_q    <= 1'b1;
         addr_s1_q   <= '0;
         addr_s2_q   <= '0;
         data_s1_q   <= '0;
         data_s2_q   <= '0;
         state_q     <= WR_IDLE;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         settle_q    <= '0;
         wr_strobe_q <= 1'b0;
         wr_idx_q    <= '0;
         wr_value_q  <= '0;
         rd_strobe_q <= 1'b0;
         rd_q        <= '0;
         fab_rdata_q <= '0;
         mem_q       <= '{default: '0};
      end else begin
         ncs_s1_q    <= nCS;
         ncs_s2_q    <= ncs_s1_q;
         nrd_s1_q    <= nRD;
         nrd_s2_q    <= nrd_s1_q;
         nrd_s3_q    <= nrd_s2_q;
         nwr_s1_q    <= nWR;
         nwr_s2_q    <= nwr_s1_q;
         addr_s1_q   <= address;
         addr_s2_q   <= addr_s1_q;
         data_s1_q   <= data;
         data_s2_q   <= data_s1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         armed_q     <= armed_d;
         settle_q    <= settle_d;
         wr_strobe_q <= wr_strobe_d;
         wr_idx_q    <= wr_idx_d;
         wr_value_q  <= wr_value_d;
         rd_strobe_q <= rd_strobe_d;
         rd_q        <= rd_d;
         fab_rdata_q <= fab_rdata_d;
         mem_q       <= mem_d;
      end
   end

   assign fab.fab_rdata = fab_rdata_q;
   assign fab.wr_strobe = wr_strobe_q;
   assign fab.wr_idx    = wr_idx_q;
   assign fab.wr_value  = wr_value_q;
   assign fab.rd_strobe = rd_strobe_q;
endmodule

// File: tb/tb_xintf_reg_responder.sv
// Randomized scoreboard bench for xintf_reg_responder; the undriven bus is
// pulled high, so a released bus reads 16'hFFFF.
`timescale 1ns/1ps
module tb_xintf_reg_responder;
   localparam int MIN_ACT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] address;
   logic        nCS, nRD, nWR;
   logic [15:0] tb_data;
   logic        tb_drv;
   tri1  [15:0] data;

   assign data = tb_drv ? tb_data : 16'bz;

   xintf_reg_responder_if #(.AW(4)) ifc ();

   xintf_reg_responder dut (
      .clk     (clk),
      .reset   (reset),
      .address (address),
      .nCS     (nCS),
      .nRD     (nRD),
      .nWR     (nWR),
      .data    (data),
      .fab     (ifc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] val;
   } wr_exp_t;

   wr_exp_t     wr_exp [$];
   int          rd_exp [$];
   logic [15:0] mem_m [16];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_win(input logic [14:0] a);
      return int'(a) >= 'h3FF0 && int'(a) < 'h3FF0 + 16;
   endfunction

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      do v = 16'($urandom); while (v == 16'hFFFF);
      return v;
   endfunction

   function automatic logic [14:0] rand_out_addr();
      logic [14:0] a;
      do a = 15'($urandom); while (in_win(a));
      return a;
   endfunction

   // Scoreboard monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (ifc.wr_strobe) begin
            chk("wr_strobe_expected", 32'(wr_exp.size() != 0), 32'd1);
            if (wr_exp.size() != 0) begin
               wr_exp_t e;
               e = wr_exp.pop_front();
               chk("wr_idx", 32'(ifc.wr_idx), 32'(e.idx));
               chk("wr_value", 32'(ifc.wr_value), 32'(e.val));
            end
         end
         if (ifc.rd_strobe) begin
            chk("rd_strobe_expected", 32'(rd_exp.size() != 0), 32'd1);
            if (rd_exp.size() != 0) void'(rd_exp.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic dsp_write(input logic [14:0] a, input logic [15:0] v, input int lead,
                            input int act, input int trail, input bit drive, input bit with_rd);
      logic [15:0] eff;
      eff = drive ? v : 16'hFFFF;
      if (in_win(a) && act >= MIN_ACT + 1) begin
         wr_exp.push_back('{4'(int'(a) - 'h3FF0), eff});
         mem_m[int'(a) - 'h3FF0] = eff;
      end
      if (in_win(a) && with_rd) rd_exp.push_back(1);
      @(negedge clk);
      address = a; nCS = 1'b0; tb_data = v; tb_drv = drive;
      cyc(lead);
      nWR = 1'b0; nRD = !with_rd;
      for (int i = 0; i < act; i++) begin
         @(negedge clk);
         if (with_rd) chk("wr_rd_bus_released", 32'(data), 32'h0000FFFF);
      end
      nWR = 1'b1; nRD = 1'b1;
      cyc(trail);
      nCS = 1'b1; tb_drv = 1'b0;
      cyc(2);
   endtask

   task automatic dsp_read(input logic [14:0] a);
      logic [15:0] exp;
      exp = in_win(a) ? mem_m[int'(a) - 'h3FF0] : 16'hFFFF;
      if (in_win(a)) rd_exp.push_back(1);
      @(negedge clk);
      address = a; nCS = 1'b0;
      cyc(3);
      chk("rd_before_nrd_z", 32'(data), 32'h0000FFFF);
      nRD = 1'b0;
      #1 chk("rd_data", 32'(data), 32'(exp));
      cyc(2);
      chk("rd_data_hold", 32'(data), 32'(exp));
      nRD = 1'b1;
      #1 chk("rd_after_nrd_z", 32'(data), 32'h0000FFFF);
      @(negedge clk);
      nCS = 1'b1;
      cyc(2);
   endtask

   task automatic fab_write(input logic [3:0] i, input logic [15:0] v);
      @(negedge clk);
      ifc.fab_idx = i; ifc.fab_wdata = v; ifc.fab_we = 1'b1;
      @(negedge clk);
      ifc.fab_we = 1'b0;
      mem_m[i] = v;
   endtask

   task automatic fab_check(input logic [3:0] i);
      @(negedge clk);
      ifc.fab_idx = i;
      @(negedge clk);
      chk("fab_rdata", 32'(ifc.fab_rdata), 32'(mem_m[i]));
   endtask

   // DSP write whose commit edge coincides with a fabric write.
   task automatic collide(input logic [3:0] didx, input logic [15:0] dval,
                          input logic [3:0] fidx, input logic [15:0] fval);
      wr_exp.push_back('{didx, dval});
      mem_m[fidx] = fval;
      mem_m[didx] = dval;
      @(negedge clk);
      address = 15'h3FF0 + 15'(didx); nCS = 1'b0; tb_data = dval; tb_drv = 1'b1;
      cyc(3);
      nWR = 1'b0;
      cyc(3);
      ifc.fab_idx = fidx; ifc.fab_wdata = fval; ifc.fab_we = 1'b1;
      @(negedge clk);
      ifc.fab_we = 1'b0;
      cyc(2);
      nWR = 1'b1;
      cyc(2);
      nCS = 1'b1; tb_drv = 1'b0;
      cyc(2);
   endtask

   initial begin
      reset = 1'b1; address = '0; nCS = 1'b1; nRD = 1'b1; nWR = 1'b1;
      tb_data = '0; tb_drv = 1'b0;
      ifc.fab_idx = '0; ifc.fab_we = 1'b0; ifc.fab_wdata = '0;
      for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
      cyc(4);
      chk("reset_fab_rdata", 32'(ifc.fab_rdata), 32'd0);
      chk("reset_wr_strobe", 32'(ifc.wr_strobe), 32'd0);
      chk("reset_wr_idx", 32'(ifc.wr_idx), 32'd0);
      chk("reset_wr_value", 32'(ifc.wr_value), 32'd0);
      chk("reset_rd_strobe", 32'(ifc.rd_strobe), 32'd0);
      chk("reset_bus_z", 32'(data), 32'h0000FFFF);
      reset = 1'b0;
      cyc(3);

      dsp_write(15'h3FFA, 16'h0001, 3, 5, 2, 1'b1, 1'b0);
      cyc(3);
      chk("held_wr_idx", 32'(ifc.wr_idx), 32'd10);
      chk("held_wr_value", 32'(ifc.wr_value), 32'd1);
      fab_check(4'd10);

      for (int a = 'h3FF0; a <= 'h3FFF; a++)
         dsp_write(15'(a), 16'(a - 'h3FFA + 1), 3, 5, 2, 1'b1, 1'b0);
      for (int a = 'h3FF0; a <= 'h3FFF; a++)
         dsp_read(15'(a));

      dsp_write(15'h0005, 16'hBEEF, 3, 5, 2, 1'b1, 1'b0);
      dsp_read(15'h0005);
      fab_check(4'd5);

      dsp_write(15'h3FF4, 16'h4444, 3, 1, 2, 1'b1, 1'b0);
      fab_check(4'd4);

      collide(4'd3, 16'hAAAA, 4'd3, 16'h5555);
      fab_check(4'd3);
      collide(4'd8, 16'h1357, 4'd9, 16'h2468);
      fab_check(4'd8);
      fab_check(4'd9);

      fab_write(4'd6, 16'h0606);
      dsp_write(15'h3FF6, 16'h0000, 3, 5, 2, 1'b0, 1'b1);
      fab_check(4'd6);

      // Reset in the middle of a write: nothing commits, and the still-low strobe is ignored.
      cyc(4);
      @(negedge clk);
      address = 15'h3FF2; nCS = 1'b0; tb_data = 16'h1234; tb_drv = 1'b1;
      cyc(3);
      nWR = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
      cyc(5);
      nWR = 1'b1;
      cyc(2);
      nCS = 1'b1; tb_drv = 1'b0;
      cyc(3);
      fab_check(4'd2);
      dsp_write(15'h3FF2, 16'h1234, 3, 5, 2, 1'b1, 1'b0);
      fab_check(4'd2);

      for (int n = 0; n < 150; n++) begin
         int op, act;
         op = int'($urandom_range(0, 5));
         act = int'($urandom_range(0, 4));
         act = (act == 0) ? 1 : act + 2;
         case (op)
            0, 1: dsp_write(15'h3FF0 + 15'($urandom_range(0, 15)), rand_val(), 3, act,
                            int'($urandom_range(1, 3)), 1'b1, 1'b0);
            2: dsp_write(rand_out_addr(), rand_val(), 3, act, 2, 1'b1, 1'b0);
            3: dsp_read(($urandom_range(0, 4) == 0) ? rand_out_addr()
                                                   : 15'h3FF0 + 15'($urandom_range(0, 15)));
            4: fab_write(4'($urandom_range(0, 15)), rand_val());
            default: fab_check(4'($urandom_range(0, 15)));
         endcase
      end

      cyc(10);
      chk("wr_queue_drained", 32'(wr_exp.size()), 32'd0);
      chk("rd_queue_drained", 32'(rd_exp.size()), 32'd0);
      for (int i = 0; i < 16; i++) fab_check(4'(i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
